gate_tt_sequencer: RTL and testbench
====================================

Name: gate_tt_sequencer

Overview:
Upstream stimulus driver and downstream response checker for the lab's small combinational gate circuits, such as the 2-input NAND-built OR.
- Drives every input vector 0..2^N_IN-1 onto the gate under test, in order.
- Holds each vector for a programmable settle time, then samples the gate output.
- Compares the sample against a parameterised expected truth table.
- Reports a pass/fail summary, mismatch count and the first failing vector.

Parameters:
N_IN, 2, number of gate inputs; number of vectors is 2^N_IN.
HOLD_CYCLES, 4, clock cycles each vector is driven; must be at least 1.
EXP_TT, 4'b1110, expected truth table; bit i is the expected output for input vector i. Width is 2^N_IN. The default is the OR function.

Ports:
clk  input  1  single system clock, rising-edge.
rst  input  1  reset; asynchronous, active-high.
start  input  1  run request; sampled on the rising edge of clk.
dut_out  input  1  output of the gate under test.
stim  output  N_IN  input vector to the gate under test; stim[0] drives inA and stim[1] drives inB.
busy  output  1  high while a run is in progress.
done  output  1  high from the end of a run until the next accepted start or reset.
pass  output  1  equals done AND (err_count == 0).
err_count  output  N_IN+1  number of mismatching vectors in the last run.
first_fail_idx  output  N_IN  index of the first mismatching vector; meaningful only when fail_valid is high.
fail_valid  output  1  high once at least one mismatch has been recorded in the current or last run.

Behaviour:
- Reset (asynchronous, takes effect immediately, mid-run included):
  - state goes to IDLE;
  - stim, busy, done, pass, err_count, first_fail_idx and fail_valid all go to 0;
  - internal idx and hold_cnt go to 0.
- State machine has three states: IDLE, RUN, DONE.
- IDLE:
  - stim = 0, busy = 0.
  - start = 1 at an edge moves to RUN on that edge. The same edge clears idx, hold_cnt, err_count, first_fail_idx, fail_valid and done.
- RUN:
  - busy = 1 and stim = idx.
  - hold_cnt increments every cycle.
- Sample edge: the edge at which hold_cnt == HOLD_CYCLES-1.
  - dut_out is compared with EXP_TT[idx].
  - On a mismatch, err_count increments. If fail_valid is 0, first_fail_idx takes idx and fail_valid goes to 1.
  - If idx == 2^N_IN-1, the state moves to DONE.
  - Otherwise idx increments and hold_cnt returns to 0.
- Run timing:
  - Each vector is driven for exactly HOLD_CYCLES cycles.
  - With start accepted at edge k, busy is high from edge k to edge k + 2^N_IN*HOLD_CYCLES.
  - done rises at that same final edge.
- DONE:
  - busy = 0, done = 1, and stim holds the last vector.
  - Results hold until the next start.
  - start = 1 at an edge restarts exactly as from IDLE.
- start while in RUN is ignored; there are no restarts or queueing.
- err_count cannot overflow; its maximum is 2^N_IN, which fits in N_IN+1 bits.
- With HOLD_CYCLES = 1, every cycle is a sample edge and the run lasts 2^N_IN cycles.
- dut_out is assumed stable when sampled; the settle time is the user's responsibility via HOLD_CYCLES.
- All outputs are registered except pass, which is combinational from done and err_count.

Test Plan:
1. Reset applied; check all outputs are 0. Then start pulsed with a correct OR gate (dut_out = stim[0] | stim[1]) and HOLD_CYCLES = 4.
   -> stim steps 0,1,2,3, each for 4 cycles.
   -> busy high for 16 cycles, then done = 1, pass = 1, err_count = 0, fail_valid = 0.
2. dut_out tied to 0.
   -> err_count = 3, first_fail_idx = 1, fail_valid = 1, pass = 0.
3. AND gate as the DUT (dut_out = stim[0] & stim[1]).
   -> mismatches at vectors 1 and 2, so err_count = 2 and first_fail_idx = 1.
4. start re-pulsed at cycle 5 of a run.
   -> ignored; done still rises 16 cycles after the original start.
5. start in DONE after scenario 2, with the OR gate restored.
   -> err_count and fail_valid clear on the start edge; new result is pass = 1.
6. rst asserted between clock edges at cycle 6 of a run.
   -> all outputs are 0 before the next edge, and no done follows.
   -> A later start gives a full 16-cycle run.

Source files
------------

// File: rtl/gate_tt_sequencer_if.sv
`default_nettype none
// ============================================================================
// Module   : gate_tt_sequencer_if
// Brief    : Run-control, stimulus and result bundle of the truth-table
//            sequencer.
// Revision : 1.0 - initial release
// ============================================================================
interface gate_tt_sequencer_if #(
    parameter int N_IN = 2
);
    logic              start;
    logic              dut_out;
    logic [N_IN-1:0]   stim;
    logic              busy;
    logic              done;
    logic              pass;
    logic [N_IN:0]     err_count;
    logic [N_IN-1:0]   first_fail_idx;
    logic              fail_valid;

    // master: the sequencer itself
    modport master (
        input  start, dut_out,
        output stim, busy, done, pass, err_count, first_fail_idx, fail_valid
    );

    // slave: run controller plus gate under test
    modport slave (
        output start, dut_out,
        input  stim, busy, done, pass, err_count, first_fail_idx, fail_valid
    );
endinterface
`default_nettype wire

// File: rtl/gate_tt_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : gate_tt_sequencer
// Brief    : Walks every input vector of a small gate, samples its output after
//            a hold time and checks it against an expected truth table.
// Revision : 1.0 - initial release
// ============================================================================
module gate_tt_sequencer #(
    parameter int                    N_IN        = 2,
    parameter int                    HOLD_CYCLES = 4,
    parameter logic [2**N_IN-1:0]    EXP_TT      = 4'b1110
) (
    input  wire                      clk,
    input  wire                      rst,
    gate_tt_sequencer_if.master      bus
);

    localparam int              c_HW        = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
    localparam logic [c_HW-1:0] c_HOLD_LAST = c_HW'(HOLD_CYCLES - 1);
    localparam logic [N_IN-1:0] c_IDX_LAST  = {N_IN{1'b1}};

    localparam logic [1:0] c_IDLE = 2'd0;
    localparam logic [1:0] c_RUN  = 2'd1;
    localparam logic [1:0] c_DONE = 2'd2;

    logic [1:0]       r_state;
    logic [1:0]       w_state_nxt;
    logic [N_IN-1:0]  r_idx;
    logic [c_HW-1:0]  r_hold_cnt;
    logic [N_IN:0]    r_err_count;
    logic [N_IN-1:0]  r_first_fail_idx;
    logic             r_fail_valid;
    logic             r_busy;
    logic             r_done;

    logic             w_start_acc;
    logic             w_sample;
    logic             w_mismatch;
    logic             w_last;

    // start is only honoured outside a run; RUN never restarts or queues
    assign w_start_acc = bus.start && (r_state != c_RUN);
    assign w_sample    = (r_state == c_RUN) && (r_hold_cnt == c_HOLD_LAST);
    assign w_mismatch  = w_sample && (bus.dut_out != EXP_TT[r_idx]);
    assign w_last      = (r_idx == c_IDX_LAST);

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_IDLE:  if (w_start_acc)         w_state_nxt = c_RUN;
            c_RUN:   if (w_sample && w_last)  w_state_nxt = c_DONE;
            c_DONE:  if (w_start_acc)         w_state_nxt = c_RUN;
            default:                          w_state_nxt = c_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= c_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_idx            <= '0;
            r_hold_cnt       <= '0;
            r_err_count      <= '0;
            r_first_fail_idx <= '0;
            r_fail_valid     <= 1'b0;
            r_busy           <= 1'b0;
            r_done           <= 1'b0;
        end else if (w_start_acc) begin
            r_idx            <= '0;
            r_hold_cnt       <= '0;
            r_err_count      <= '0;
            r_first_fail_idx <= '0;
            r_fail_valid     <= 1'b0;
            r_busy           <= 1'b1;
            r_done           <= 1'b0;
        end else if (r_state == c_RUN) begin
            if (w_sample) begin
                if (w_mismatch) begin
                    r_err_count <= r_err_count + (N_IN+1)'(1);
                    if (!r_fail_valid) begin
                        r_first_fail_idx <= r_idx;
                        r_fail_valid     <= 1'b1;
                    end
                end
                if (w_last) begin
                    r_busy <= 1'b0;
                    r_done <= 1'b1;
                end else begin
                    r_idx      <= r_idx + N_IN'(1);
                    r_hold_cnt <= '0;
                end
            end else begin
                r_hold_cnt <= r_hold_cnt + c_HW'(1);
            end
        end
    end

    // r_idx is zero in IDLE and frozen on the last vector in DONE
    assign bus.stim           = r_idx;
    assign bus.busy           = r_busy;
    assign bus.done           = r_done;
    assign bus.err_count      = r_err_count;
    assign bus.first_fail_idx = r_first_fail_idx;
    assign bus.fail_valid     = r_fail_valid;
    assign bus.pass           = r_done && (r_err_count == '0);

endmodule
`default_nettype wire

// File: tb/tb_gate_tt_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_gate_tt_sequencer
// Brief    : Directed self-checking bench for gate_tt_sequencer.
// Revision : 1.0 - initial release
// ============================================================================
module tb_gate_tt_sequencer;

    logic clk;
    logic rst;
    int   mode;       // 0: OR, 1: tied 0, 2: AND, 3: tied 1
    int   checks;
    int   failures;

    gate_tt_sequencer_if #(.N_IN(2)) bus  ();
    gate_tt_sequencer_if #(.N_IN(2)) bus1 ();

    gate_tt_sequencer #(.N_IN(2), .HOLD_CYCLES(4), .EXP_TT(4'b1110)) u_dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    gate_tt_sequencer #(.N_IN(2), .HOLD_CYCLES(1), .EXP_TT(4'b1110)) u_dut1 (
        .clk (clk),
        .rst (rst),
        .bus (bus1)
    );

    assign bus.dut_out = (mode == 0) ? (bus.stim[0] | bus.stim[1]) :
                         (mode == 2) ? (bus.stim[0] & bus.stim[1]) :
                         (mode == 3);
    assign bus1.dut_out = bus1.stim[0] | bus1.stim[1];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_stim"}, 32'(bus.stim), 0);
        check({tag, "_busy"}, 32'(bus.busy), 0);
        check({tag, "_done"}, 32'(bus.done), 0);
        check({tag, "_pass"}, 32'(bus.pass), 0);
        check({tag, "_err"},  32'(bus.err_count), 0);
        check({tag, "_ffi"},  32'(bus.first_fail_idx), 0);
        check({tag, "_fv"},   32'(bus.fail_valid), 0);
    endtask

    // Full run from a negedge; repulse_at re-asserts start during the run
    task automatic run(input string tag, input int repulse_at,
                       input int e_err, input int e_ffi, input int e_fv, input int e_pass);
        @(negedge clk);
        bus.start = 1'b1;
        @(negedge clk);
        for (int j = 0; j < 16; j++) begin
            bus.start = (j == repulse_at);
            if (j == 0) begin
                check({tag, "_clr_err"},  32'(bus.err_count), 0);
                check({tag, "_clr_fv"},   32'(bus.fail_valid), 0);
            end
            check($sformatf("%s_stim%0d", tag, j), 32'(bus.stim), 32'(j / 4));
            check($sformatf("%s_busy%0d", tag, j), 32'(bus.busy), 1);
            check($sformatf("%s_done%0d", tag, j), 32'(bus.done), 0);
            @(negedge clk);
        end
        bus.start = 1'b0;
        check({tag, "_end_busy"}, 32'(bus.busy), 0);
        check({tag, "_end_done"}, 32'(bus.done), 1);
        check({tag, "_end_stim"}, 32'(bus.stim), 3);
        check({tag, "_err"},      32'(bus.err_count), 32'(e_err));
        check({tag, "_ffi"},      32'(bus.first_fail_idx), 32'(e_ffi));
        check({tag, "_fv"},       32'(bus.fail_valid), 32'(e_fv));
        check({tag, "_pass"},     32'(bus.pass), 32'(e_pass));
        repeat (3) @(negedge clk);
        check({tag, "_hold_done"}, 32'(bus.done), 1);
        check({tag, "_hold_err"},  32'(bus.err_count), 32'(e_err));
    endtask

    initial begin
        checks     = 0;
        failures   = 0;
        mode       = 0;
        rst        = 1'b1;
        bus.start  = 1'b0;
        bus1.start = 1'b0;
        repeat (2) @(negedge clk);
        check_all_zero("reset");
        rst = 1'b0;
        @(negedge clk);

        mode = 0; run("or",    -1, 0, 0, 0, 1);
        mode = 1; run("zero",  -1, 3, 1, 1, 0);
        check("zero_done_err", 32'(bus.err_count), 3);
        mode = 0; run("restart", -1, 0, 0, 0, 1);
        mode = 2; run("and",   -1, 2, 1, 1, 0);
        mode = 0; run("repulse", 5, 0, 0, 0, 1);

        // asynchronous reset mid-run after vector 0 already mismatched
        mode = 3;
        @(negedge clk);
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        repeat (6) @(negedge clk);
        check("pre_rst_err", 32'(bus.err_count), 1);
        check("pre_rst_fv",  32'(bus.fail_valid), 1);
        #1 rst = 1'b1;
        #1 check_all_zero("async_rst");
        rst = 1'b0;
        for (int j = 0; j < 20; j++) begin
            @(negedge clk);
            check($sformatf("post_rst_done%0d", j), 32'(bus.done), 0);
        end
        mode = 0; run("after_rst", -1, 0, 0, 0, 1);

        // HOLD_CYCLES = 1: every cycle is a sample edge
        @(negedge clk);
        bus1.start = 1'b1;
        @(negedge clk);
        bus1.start = 1'b0;
        for (int j = 0; j < 4; j++) begin
            check($sformatf("h1_stim%0d", j), 32'(bus1.stim), 32'(j));
            check($sformatf("h1_busy%0d", j), 32'(bus1.busy), 1);
            @(negedge clk);
        end
        check("h1_done", 32'(bus1.done), 1);
        check("h1_busy", 32'(bus1.busy), 0);
        check("h1_pass", 32'(bus1.pass), 1);
        check("h1_err",  32'(bus1.err_count), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
